// File: rtl/mod8_timer_pkg.sv
// Shared definitions for the mod-8 down timer.
//   timer_state_e : FSM state encoding (StIdle, StRun)
//   DEFAULT_WIDTH : default counter width (3 gives the mod-8 range)
//   max_load()    : largest programmable load value for a given width
//   MAX_LOAD      : max_load() evaluated at DEFAULT_WIDTH
package mod8_timer_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } timer_state_e;

  localparam int unsigned DEFAULT_WIDTH = 3;

  function automatic int unsigned max_load(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  localparam int unsigned MAX_LOAD = max_load(DEFAULT_WIDTH);

endpackage

// File: rtl/dtimer_expiry.sv
// Combinational next-count / expiry decode for the down timer.
// Ports:
//   count      in  WIDTH  current count (never 0 while running)
//   reload_reg in  WIDTH  value captured by the last load
//   mode       in  1      1 = auto-reload on expiry, 0 = one-shot
//   next_count out WIDTH  count after one enabled cycle
//   expire     out 1      current cycle is the expiry cycle (count == 1)
module dtimer_expiry
  import mod8_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] reload_reg,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count,
  output logic             expire
);

  always_comb begin
    expire     = (count == WIDTH'(1));
    next_count = count - WIDTH'(1);
    // The final decrement lands on reload_reg or zero, so count never wraps.
    if (expire) begin
      next_count = mode ? reload_reg : '0;
    end
  end

endmodule

// File: rtl/mod8_down_timer.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Optional feature: define MOD8_DOWN_TIMER_RELOAD_EN to add the auto_reload
// port; without it the timer is always one-shot.
// Ports:
//   clk         in  1      clock, rising edge
//   rst         in  1      asynchronous active-high reset
//   load        in  1      load strobe, samples load_val (beats en)
//   load_val    in  WIDTH  start / reload value (0 leaves the timer idle)
//   en          in  1      count enable, one decrement per enabled cycle
//   auto_reload in  1      reload on expiry (only with MOD8_DOWN_TIMER_RELOAD_EN)
//   count       out WIDTH  current count, registered
//   tc          out 1      terminal-count pulse, registered, one cycle
//   busy        out 1      high while running
module mod8_down_timer
  import mod8_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
`ifdef MOD8_DOWN_TIMER_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  timer_state_e     state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  logic             mode;
  logic [WIDTH-1:0] next_count;
  logic             expire;

`ifdef MOD8_DOWN_TIMER_RELOAD_EN
  assign mode = auto_reload;
`else
  assign mode = 1'b0;
`endif

  dtimer_expiry #(
    .WIDTH(WIDTH)
  ) u_expiry (
    .count      (count_q),
    .reload_reg (reload_q),
    .mode       (mode),
    .next_count (next_count),
    .expire     (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else if (load) begin
      // Load wins over a coincident expiry, so no tc pulse on this edge.
      count_q  <= load_val;
      reload_q <= load_val;
      tc_q     <= 1'b0;
      state_q  <= (load_val != '0) ? StRun : StIdle;
    end else begin
      case (state_q)
        StRun: begin
          if (en) begin
            count_q <= next_count;
            tc_q    <= expire;
            if (expire && !mode) begin
              state_q <= StIdle;
            end
          end else begin
            tc_q <= 1'b0;
          end
        end
        default: begin
          tc_q <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun);

endmodule

// File: tb/tb_mod8_down_timer.sv
module tb_mod8_down_timer;
  import mod8_timer_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int n_tests;
  int n_fail;

  mod8_down_timer #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
`ifdef MOD8_DOWN_TIMER_RELOAD_EN
    .auto_reload(auto_reload),
`endif
    .count      (count),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic [W-1:0] ecount;
    logic         etc;
    logic         ebusy;
  } vec_t;

  typedef struct {
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    string        name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected result, compare after the edge.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic e,
                      input logic [W-1:0] ec, input logic et, input logic eb,
                      input string name);
    exp_t x;
    @(negedge clk);
    load     = ld;
    load_val = lv;
    en       = e;
    sb.push_back('{count: ec, tc: et, busy: eb, name: name});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, " scoreboard"}, 0, 1);
    end else begin
      x = sb.pop_front();
      check({x.name, " count"}, int'(count), int'(x.count));
      check({x.name, " tc"}, int'(tc), int'(x.tc));
      check({x.name, " busy"}, int'(busy), int'(x.busy));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] maxv;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    load        = 1'b0;
    load_val    = '0;
    en          = 1'b0;
    auto_reload = 1'b0;
    maxv        = W'(MAX_LOAD);

    @(negedge clk);
    @(negedge clk);
    check("reset count", int'(count), 0);
    check("reset tc", int'(tc), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;

    // {load, load_val, en, exp count, exp tc, exp busy}
    vecs = '{
      // one-shot load 3
      '{1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0},
      // stall: load 2, en 1,0,0,1
      '{1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0},
      '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0},
      // zero load stays idle, en ignored
      '{1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0},
      // collision: load on the expiry cycle wins
      '{1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b1},
      '{1'b1, 3'd6, 1'b1, 3'd6, 1'b0, 1'b1},
      '{1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1},
      // load 0 mid-run stops the timer
      '{1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0},
      '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0}
    };
    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ecount, vecs[i].etc,
           vecs[i].ebusy, $sformatf("vec%0d", i));
    end

    // Max load, with en high on the load cycle (ignored): expires after 7 enabled edges.
    step(1'b1, maxv, 1'b1, maxv, 1'b0, 1'b1, "max load");
    for (int k = 1; k <= int'(MAX_LOAD); k++) begin
      step(1'b0, '0, 1'b1, W'(int'(MAX_LOAD) - k), (k == int'(MAX_LOAD)),
           (k != int'(MAX_LOAD)), $sformatf("max k%0d", k));
    end

    // Asynchronous reset mid-count clears outputs without a clock edge.
    step(1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b1, "rst load");
    step(1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b1, "rst c1");
    step(1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1, "rst c2");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst count", int'(count), 0);
    check("async rst tc", int'(tc), 0);
    check("async rst busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b1, 3'd0, 1'b0, 1'b0, $sformatf("post rst %0d", k));
    end

`ifdef MOD8_DOWN_TIMER_RELOAD_EN
    // Auto-reload load 4: tc at enabled cycles 4, 8, 12.
    auto_reload = 1'b1;
    step(1'b1, 3'd4, 1'b0, 3'd4, 1'b0, 1'b1, "ar load");
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, '0, 1'b1, (k % 4 == 0) ? 3'd4 : W'(4 - (k % 4)), (k % 4 == 0), 1'b1,
           $sformatf("ar k%0d", k));
    end
    // Dropping auto_reload before the next expiry makes it one-shot.
    auto_reload = 1'b0;
    step(1'b0, '0, 1'b1, 3'd3, 1'b0, 1'b1, "ar off 1");
    step(1'b0, '0, 1'b1, 3'd2, 1'b0, 1'b1, "ar off 2");
    step(1'b0, '0, 1'b1, 3'd1, 1'b0, 1'b1, "ar off 3");
    step(1'b0, '0, 1'b1, 3'd0, 1'b1, 1'b0, "ar off 4");
    step(1'b0, '0, 1'b1, 3'd0, 1'b0, 1'b0, "ar off 5");
`endif

    if (sb.size() != 0) begin
      check("scoreboard drained", sb.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
